// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default sizes and
// the round-robin side encoding.
package regfile_write_arbiter_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NREGS      = 4;
    localparam int REG_IDX_W      = $clog2(DEF_NREGS);

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } rr_side_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. req/gnt bit 0 is side A, bit 1 is side B.
// The pointer only moves, to the loser, when both sides requested.
module rr_arb2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_side_t ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == SIDE_A) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= SIDE_A;
        end else if (req == 2'b11) begin
            ptr <= (ptr == SIDE_A) ? SIDE_B : SIDE_A;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU (A) and load unit (B), and
// keeps a pending-write scoreboard that flags read hazards and stalls WAW issue.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NREGS      = DEF_NREGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_wnum,
    input  logic [WIDTH-1:0]      a_wdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_wnum,
    input  logic [WIDTH-1:0]      b_wdata,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] rnum1,
    input  logic [ADDR_WIDTH-1:0] rnum2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_wnum,
    output logic [WIDTH-1:0]      rf_wdata
);

    localparam int IDX_W = $clog2(NREGS);

    logic [1:0]            gnt;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_wnum;
    logic [WIDTH-1:0]      sel_wdata;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      iss_idx;
    logic [IDX_W-1:0]      clr_idx;
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_nxt;
    logic                  unused_hi;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_valid, a_valid}),
        .gnt (gnt)
    );

    assign a_ready   = gnt[0];
    assign b_ready   = gnt[1];
    assign xfer      = |gnt;
    assign sel_wnum  = gnt[1] ? b_wnum  : a_wnum;
    assign sel_wdata = gnt[1] ? b_wdata : a_wdata;
    assign sel_idx   = sel_wnum[IDX_W-1:0];
    assign iss_idx   = issue_rd[IDX_W-1:0];
    assign clr_idx   = rf_wnum[IDX_W-1:0];

    // Writes to r0 are accepted but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_write <= 1'b0;
            rf_wnum  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_write <= xfer && (sel_idx != '0);
            if (xfer) begin
                rf_wnum  <= sel_wnum;
                rf_wdata <= sel_wdata;
            end
        end
    end

    assign issue_ready = !(issue_valid && pending[iss_idx]);

    // Clear on the regfile write edge; a same-edge reservation of that index wins.
    always_comb begin
        pending_nxt = pending;
        if (rf_write) begin
            pending_nxt[clr_idx] = 1'b0;
        end
        if (issue_valid && issue_ready && (iss_idx != '0)) begin
            pending_nxt[iss_idx] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy1 = pending[rnum1[IDX_W-1:0]];
    assign busy2 = pending[rnum2[IDX_W-1:0]];

    assign unused_hi = ^{issue_rd[ADDR_WIDTH-1:IDX_W], rnum1[ADDR_WIDTH-1:IDX_W],
                         rnum2[ADDR_WIDTH-1:IDX_W]};

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, reset-mid-write
// sequence, then random traffic against a behavioural model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 0, b_valid = 0, issue_valid = 0;
    logic [4:0]  a_wnum = 0, b_wnum = 0, issue_rd = 0, rnum1 = 0, rnum2 = 0;
    logic [31:0] a_wdata = 0, b_wdata = 0;
    logic        a_ready, b_ready, issue_ready, busy1, busy2, rf_write;
    logic [4:0]  rf_wnum;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_wnum(a_wnum), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_wnum(b_wnum), .b_wdata(b_wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rnum1(rnum1), .rnum2(rnum2), .busy1(busy1), .busy2(busy2),
        .rf_write(rf_write), .rf_wnum(rf_wnum), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic        av; logic [4:0] aw; logic [31:0] ad;
        logic        bv; logic [4:0] bw; logic [31:0] bd;
        logic        iv; logic [4:0] rd; logic [4:0] r1; logic [4:0] r2;
        logic        e_ar, e_br, e_ir, e_b1, e_b2, e_w;
        logic [4:0]  e_wn; logic [31:0] e_wd;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic av, logic [4:0] aw, logic [31:0] ad,
                                logic bv, logic [4:0] bw, logic [31:0] bd,
                                logic iv, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                                logic e_ar, logic e_br, logic e_ir, logic e_b1, logic e_b2,
                                logic e_w, logic [4:0] e_wn, logic [31:0] e_wd);
        vec_t v;
        v.av = av; v.aw = aw; v.ad = ad; v.bv = bv; v.bw = bw; v.bd = bd;
        v.iv = iv; v.rd = rd; v.r1 = r1; v.r2 = r2;
        v.e_ar = e_ar; v.e_br = e_br; v.e_ir = e_ir; v.e_b1 = e_b1; v.e_b2 = e_b2;
        v.e_w = e_w; v.e_wn = e_wn; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                         input logic bv, input logic [4:0] bw, input logic [31:0] bd,
                         input logic iv, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2);
        a_valid = av; a_wnum = aw; a_wdata = ad;
        b_valid = bv; b_wnum = bw; b_wdata = bd;
        issue_valid = iv; issue_rd = rd; rnum1 = r1; rnum2 = r2;
    endtask

    // Behavioural model state
    bit          m_pend[4];
    int          m_turn;       // 0: A preferred on contention, 1: B preferred
    bit          m_wr;
    logic [4:0]  m_wn;
    logic [31:0] m_wd;

    initial begin
        // after reset the pointer favours A
        tbl[0]  = mk(1,1,32'h11,1,2,32'h22, 0,0,0,0, 1,0,1,0,0, 0,0,0);
        tbl[1]  = mk(1,1,32'h11,1,2,32'h22, 0,0,0,0, 0,1,1,0,0, 1,1,32'h11);
        tbl[2]  = mk(1,1,32'h11,1,2,32'h22, 0,0,0,0, 1,0,1,0,0, 1,2,32'h22);
        tbl[3]  = mk(1,1,32'h11,1,2,32'h22, 0,0,0,0, 0,1,1,0,0, 1,1,32'h11);
        tbl[4]  = mk(0,0,0,0,0,0,           1,2,2,0, 0,0,1,0,0, 1,2,32'h22);
        tbl[5]  = mk(0,0,0,0,0,0,           0,0,2,0, 0,0,1,1,0, 0,0,0);
        tbl[6]  = mk(0,0,0,1,2,32'hDEADBEEF,0,0,2,0, 0,1,1,1,0, 0,0,0);
        tbl[7]  = mk(0,0,0,0,0,0,           0,0,2,0, 0,0,1,1,0, 1,2,32'hDEADBEEF);
        tbl[8]  = mk(0,0,0,0,0,0,           0,0,2,0, 0,0,1,0,0, 0,0,0);
        tbl[9]  = mk(0,0,0,0,0,0,           1,3,0,3, 0,0,1,0,0, 0,0,0);
        tbl[10] = mk(0,0,0,0,0,0,           1,3,0,3, 0,0,0,0,1, 0,0,0);
        tbl[11] = mk(1,3,32'h33,0,0,0,      1,3,0,3, 1,0,0,0,1, 0,0,0);
        tbl[12] = mk(0,0,0,0,0,0,           1,3,0,3, 0,0,0,0,1, 1,3,32'h33);
        tbl[13] = mk(0,0,0,0,0,0,           1,3,0,3, 0,0,1,0,0, 0,0,0);
        tbl[14] = mk(0,0,0,0,0,0,           0,0,0,3, 0,0,1,0,1, 0,0,0);
        tbl[15] = mk(1,0,32'h1234,0,0,0,    1,0,0,0, 1,0,1,0,0, 0,0,0);
        tbl[16] = mk(0,0,0,0,0,0,           1,0,0,0, 0,0,1,0,0, 0,0,0);
        tbl[17] = mk(1,1,32'h55,0,0,0,      0,0,0,0, 1,0,1,0,0, 0,0,0);
        tbl[18] = mk(0,0,0,0,0,0,           1,1,1,0, 0,0,1,0,0, 1,1,32'h55);
        tbl[19] = mk(0,0,0,0,0,0,           0,0,1,0, 0,0,1,1,0, 0,0,0);
        tbl[20] = mk(0,0,0,0,0,0,           1,1,1,3, 0,0,0,1,1, 0,0,0);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rf_write", rf_write, 0);
        chk("reset_rf_wnum", rf_wnum, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(tbl[i].av, tbl[i].aw, tbl[i].ad, tbl[i].bv, tbl[i].bw, tbl[i].bd,
                  tbl[i].iv, tbl[i].rd, tbl[i].r1, tbl[i].r2);
            #1;
            chk($sformatf("v%0d_a_ready", i), a_ready, tbl[i].e_ar);
            chk($sformatf("v%0d_b_ready", i), b_ready, tbl[i].e_br);
            chk($sformatf("v%0d_issue_ready", i), issue_ready, tbl[i].e_ir);
            chk($sformatf("v%0d_busy1", i), busy1, tbl[i].e_b1);
            chk($sformatf("v%0d_busy2", i), busy2, tbl[i].e_b2);
            chk($sformatf("v%0d_rf_write", i), rf_write, tbl[i].e_w);
            if (tbl[i].e_w) begin
                chk($sformatf("v%0d_rf_wnum", i), rf_wnum, tbl[i].e_wn);
                chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tbl[i].e_wd);
            end
        end

        // Reset asserted while a write is on the port and r1/r3 are pending
        @(negedge clk);
        drive(1, 2, 32'h77, 0, 0, 0, 0, 0, 1, 3);
        #1 chk("rst_seq_a_ready", a_ready, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 1, 3);
        #1;
        chk("rst_seq_pre_write", rf_write, 1);
        chk("rst_seq_pre_busy1", busy1, 1);
        chk("rst_seq_pre_issue_ready", issue_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_seq_rf_write", rf_write, 0);
        chk("rst_seq_rf_wnum", rf_wnum, 0);
        chk("rst_seq_busy1", busy1, 0);
        chk("rst_seq_busy2", busy2, 0);
        chk("rst_seq_issue_ready", issue_ready, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        foreach (m_pend[k]) m_pend[k] = 0;
        m_turn = 0; m_wr = 0; m_wn = 0; m_wd = 0;

        for (int c = 0; c < 500; c++) begin
            logic av, bv, iv, e_ar, e_br, e_ir, acc_a, acc_b;
            logic [4:0]  aw, bw, rd, r1, r2, wn_sel;
            logic [31:0] ad, bd;
            int          idx;
            @(negedge clk);
            av = ($urandom_range(0, 1) == 1);
            bv = ($urandom_range(0, 1) == 1);
            iv = ($urandom_range(0, 2) != 0);
            aw = 5'($urandom); bw = 5'($urandom); rd = 5'($urandom);
            r1 = 5'($urandom); r2 = 5'($urandom);
            ad = $urandom; bd = $urandom;
            drive(av, aw, ad, bv, bw, bd, iv, rd, r1, r2);

            acc_a = av && (!bv || m_turn == 0);
            acc_b = bv && (!av || m_turn == 1);
            e_ar  = acc_a;
            e_br  = acc_b;
            e_ir  = !(iv && m_pend[rd % 4]);
            #1;
            chk("rnd_a_ready", a_ready, e_ar);
            chk("rnd_b_ready", b_ready, e_br);
            chk("rnd_issue_ready", issue_ready, e_ir);
            chk("rnd_busy1", busy1, m_pend[r1 % 4]);
            chk("rnd_busy2", busy2, m_pend[r2 % 4]);
            chk("rnd_rf_write", rf_write, m_wr);
            if (m_wr) begin
                chk("rnd_rf_wnum", rf_wnum, m_wn);
                chk("rnd_rf_wdata", rf_wdata, m_wd);
            end

            // advance the model across the coming rising edge
            if (m_wr) m_pend[m_wn % 4] = 0;
            idx = rd % 4;
            if (iv && e_ir && idx != 0) m_pend[idx] = 1;
            if (av && bv) m_turn = 1 - m_turn;
            wn_sel = acc_b ? bw : aw;
            m_wr = (acc_a || acc_b) && (wn_sel % 4 != 0);
            if (acc_a || acc_b) begin
                m_wn = wn_sel;
                m_wd = acc_b ? bd : ad;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
